mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction cache and the data cache. Merges their two block-level memory request ports onto the single slow-memory port.
- Each cache side uses the same protocol the caches drive:
  - read/write strobes held high until ready;
  - 28-bit block address;
  - 128-bit block data;
  - one-cycle ready pulse.
- Serialises requests with fixed or round-robin priority and routes ready/rdata back to the granted cache only.

Parameters:
- ADDR_W, 28, block address width (word address bits [29:2])
- DATA_W, 128, block data width (4 words)
- RR, 1, 1 = round-robin between caches on simultaneous requests; 0 = fixed priority, D-cache wins

Ports:
- clk  in  1  clock, all logic on rising edge
- proc_reset  in  1  synchronous, active-high reset
- ic_read  in  1  I-cache block read request, held until ic_ready
- ic_write  in  1  I-cache block write request, held until ic_ready
- ic_addr  in  ADDR_W  I-cache block address
- ic_wdata  in  DATA_W  I-cache write block
- ic_rdata  out  DATA_W  read block to I-cache
- ic_ready  out  1  one-cycle completion pulse to I-cache
- dc_read, dc_write, dc_addr, dc_wdata, dc_rdata, dc_ready: same as ic_*, for the D-cache
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory block address
- mem_wdata  out  DATA_W  memory write block
- mem_rdata  in  DATA_W  memory read block, valid when mem_ready
- mem_ready  in  1  memory completion pulse

Behaviour:
- States:
  - IDLE
  - BUSY_I: I-cache granted
  - BUSY_D: D-cache granted
- Register last_grant (0 = I, 1 = D).
- Port request: req_x = x_read | x_write. If read and write are both high on one port, write takes precedence. The caches never do this.
- IDLE transitions:
  - only ic req → BUSY_I
  - only dc req → BUSY_D
  - both requesting:
    - RR=1 → grant the port ≠ last_grant
    - RR=0 → BUSY_D
  - neither → stay IDLE
- On the IDLE→BUSY edge, register:
  - mem_addr and mem_wdata ← granted port's addr/wdata
  - mem_write ← port write
  - mem_read ← port read & ~port write
  - last_grant ← granted port
- BUSY_x:
  - outputs held stable regardless of cache-side input changes.
  - On a cycle with mem_ready=1:
    - next state IDLE; mem_read and mem_write cleared at that edge.
    - x_ready = 1 combinationally in that same cycle.
  - Otherwise stay in BUSY_x.
- Readiness and data routing:
  - ic_ready = mem_ready & (state==BUSY_I)
  - dc_ready = mem_ready & (state==BUSY_D)
  - ic_rdata and dc_rdata are both driven from mem_rdata; only the ready-qualified port samples it.
- mem_ready in IDLE is ignored: no ready to either cache, no state change.
- Mandatory IDLE cycle after every completion. This guarantees a cache's stale strobe is never re-granted: the cache drops or changes its strobe at the same edge the arbiter returns to IDLE.
- Back-to-back traffic: a D-cache write-back immediately followed by its refill read is two separate grants. Under RR=1 a pending I-cache request is served between them; this is legal.
- Latency: a request first seen in IDLE at cycle t puts the memory strobe high from cycle t+1. Memory latency is added unchanged. The minimum turnaround between grants is 1 IDLE cycle.
- Reset (any state, including mid-transaction):
  - state=IDLE, mem_read=mem_write=0, mem_addr=0, mem_wdata=0, last_grant=I.
  - ic_ready=dc_ready=0.
  - An in-flight memory access is abandoned. The memory model is reset by the same proc_reset.
- No buffering: at most one outstanding memory transaction.

Decomposition:
- Shared package holds:
  - state encodings IDLE/BUSY_I/BUSY_D (2-bit)
  - ADDR_W=28 and DATA_W=128 constants, also used by the caches and the memory model
  - GRANT_I/GRANT_D encodings
- One natural sub-module: arb_rr2. It is a combinational 2-requester priority picker taking req_i, req_d, last_grant and RR, and returning the grant. Everything else stays in mem_arbiter.

Test Plan:
- ic_read=1, ic_addr=28'h0000010; memory returns 128'hA5.. after 5 cycles → mem_read high from t+1 with mem_addr=28'h0000010; ic_ready pulses 1 cycle with ic_rdata=128'hA5..; dc_ready stays 0.
- ic_read and dc_read asserted in the same cycle, RR=1, after reset → D granted first (last_grant=I), then I after one IDLE cycle; a second simultaneous pair grants I first.
- RR=0, dc continuously re-requests while ic waits → D always granted; I granted only in an IDLE cycle with dc_read=dc_write=0.
- dc_write with addr 28'h0000123, wdata 128'hDEAD.., then dc_read at addr 28'h0000456 right after dc_ready → two grants: mem_write with the correct wdata, IDLE cycle, mem_read at 28'h0000456; no duplicate write.
- mem_ready pulsed while IDLE → no ic_ready/dc_ready, state and outputs unchanged.
- proc_reset asserted during BUSY_I with mem_read=1 → next cycle all mem_* and ready outputs 0, state IDLE; a subsequent dc_read completes normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the cache-to-memory arbiter: block geometry, FSM state
// encodings and grant encodings, also used by the caches and the memory model.
package mem_arbiter_pkg;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-requester priority picker: round-robin against the previous grant, or
// fixed priority with the D-cache winning, when both caches request together.
module arb_rr2 #(
    parameter bit RR = 1'b1
) (
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);
    import mem_arbiter_pkg::*;

    always_comb begin
        grant_valid = req_i | req_d;
        grant       = GRANT_I;
        if (req_i && req_d) begin
            grant = RR ? ~last_grant : GRANT_D;
        end else if (req_d) begin
            grant = GRANT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache and D-cache block requests onto one slow-memory port and
// routes the completion pulse back to whichever cache owns the transaction.
module mem_arbiter #(
    parameter int ADDR_W = mem_arbiter_pkg::ADDR_W,
    parameter int DATA_W = mem_arbiter_pkg::DATA_W,
    parameter bit RR     = 1'b1
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              ic_read,
    input  logic              ic_write,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic [DATA_W-1:0] ic_wdata,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_ready,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        state_dbg
);
    import mem_arbiter_pkg::*;

    // Handshake: each cache holds read/write until its one-cycle ready pulse;
    // the memory sees a strobe held until its one-cycle mem_ready pulse.
    arb_state_e state, next_state;
    logic       last_grant;
    logic       req_i, req_d;
    logic       grant_valid, grant;
    logic       load;

    assign req_i = ic_read | ic_write;
    assign req_d = dc_read | dc_write;

    arb_rr2 #(.RR(RR)) u_pick (
        .req_i       (req_i),
        .req_d       (req_d),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Grants are only taken from IDLE, which forces one idle cycle after every
    // completion so a strobe the cache is about to drop is never re-granted.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    load       = 1'b1;
                    next_state = (grant == GRANT_D) ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            last_grant <= GRANT_I;
        end else if (load) begin
            last_grant <= grant;
            if (grant == GRANT_D) begin
                mem_addr  <= dc_addr;
                mem_wdata <= dc_wdata;
                mem_write <= dc_write;
                mem_read  <= dc_read & ~dc_write;
            end else begin
                mem_addr  <= ic_addr;
                mem_wdata <= ic_wdata;
                mem_write <= ic_write;
                mem_read  <= ic_read & ~ic_write;
            end
        end else if ((state != IDLE) && mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end
    end

    assign ic_ready  = mem_ready & (state == BUSY_I);
    assign dc_ready  = mem_ready & (state == BUSY_D);
    assign ic_rdata  = mem_rdata;
    assign dc_rdata  = mem_rdata;
    assign state_dbg = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (round-robin and fixed priority) with a
// transaction-level ownership model checked every cycle plus directed scenarios.
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int TW = 1 + AW + DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          proc_reset;
    logic          ic_read[2], ic_write[2], dc_read[2], dc_write[2], mem_ready[2];
    logic [AW-1:0] ic_addr[2], dc_addr[2];
    logic [DW-1:0] ic_wdata[2], dc_wdata[2], mem_rdata[2];
    logic [DW-1:0] ic_rdata[2], dc_rdata[2], mem_wdata[2];
    logic          ic_ready[2], dc_ready[2], mem_read[2], mem_write[2];
    logic [AW-1:0] mem_addr[2];
    logic [1:0]    state_dbg[2];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(1'b1)) dut0 (
        .clk(clk), .proc_reset(proc_reset),
        .ic_read(ic_read[0]), .ic_write(ic_write[0]), .ic_addr(ic_addr[0]), .ic_wdata(ic_wdata[0]),
        .ic_rdata(ic_rdata[0]), .ic_ready(ic_ready[0]),
        .dc_read(dc_read[0]), .dc_write(dc_write[0]), .dc_addr(dc_addr[0]), .dc_wdata(dc_wdata[0]),
        .dc_rdata(dc_rdata[0]), .dc_ready(dc_ready[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .mem_ready(mem_ready[0]),
        .state_dbg(state_dbg[0])
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(1'b0)) dut1 (
        .clk(clk), .proc_reset(proc_reset),
        .ic_read(ic_read[1]), .ic_write(ic_write[1]), .ic_addr(ic_addr[1]), .ic_wdata(ic_wdata[1]),
        .ic_rdata(ic_rdata[1]), .ic_ready(ic_ready[1]),
        .dc_read(dc_read[1]), .dc_write(dc_write[1]), .dc_addr(dc_addr[1]), .dc_wdata(dc_wdata[1]),
        .dc_rdata(dc_rdata[1]), .dc_ready(dc_ready[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .mem_ready(mem_ready[1]),
        .state_dbg(state_dbg[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ownership model: who holds the memory port (0 none, 1 I, 2 D) and the
    // transaction captured at grant time.
    int            m_owner[2];
    bit            m_last_d[2];
    bit            m_rd[2], m_wr[2];
    logic [AW-1:0] m_addr[2];
    logic [DW-1:0] m_wdata[2];
    bit            model_on = 1'b0;

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = 0; m_last_d[k] = 1'b0; m_rd[k] = 1'b0; m_wr[k] = 1'b0;
            m_addr[k] = '0; m_wdata[k] = '0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit ri, rd, pick_d;
            ri = ic_read[k] | ic_write[k];
            rd = dc_read[k] | dc_write[k];
            if (proc_reset) begin
                m_owner[k] = 0; m_last_d[k] = 1'b0; m_rd[k] = 1'b0; m_wr[k] = 1'b0;
                m_addr[k] = '0; m_wdata[k] = '0;
            end else if (m_owner[k] == 0) begin
                if (ri || rd) begin
                    if (ri && rd) pick_d = (k == 0) ? !m_last_d[k] : 1'b1;
                    else          pick_d = rd;
                    m_owner[k]  = pick_d ? 2 : 1;
                    m_last_d[k] = pick_d;
                    m_wr[k]     = pick_d ? dc_write[k] : ic_write[k];
                    m_rd[k]     = (pick_d ? dc_read[k] : ic_read[k]) & !m_wr[k];
                    m_addr[k]   = pick_d ? dc_addr[k] : ic_addr[k];
                    m_wdata[k]  = pick_d ? dc_wdata[k] : ic_wdata[k];
                end
            end else if (mem_ready[k]) begin
                m_owner[k] = 0; m_rd[k] = 1'b0; m_wr[k] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("u%0d state", k), TW'(state_dbg[k]), TW'(m_owner[k]));
                check($sformatf("u%0d mem_read", k), TW'(mem_read[k]), TW'(m_rd[k]));
                check($sformatf("u%0d mem_write", k), TW'(mem_write[k]), TW'(m_wr[k]));
                check($sformatf("u%0d mem_addr", k), TW'(mem_addr[k]), TW'(m_addr[k]));
                check($sformatf("u%0d mem_wdata", k), TW'(mem_wdata[k]), TW'(m_wdata[k]));
                check($sformatf("u%0d ic_ready", k), TW'(ic_ready[k]), TW'(mem_ready[k] && m_owner[k] == 1));
                check($sformatf("u%0d dc_ready", k), TW'(dc_ready[k]), TW'(mem_ready[k] && m_owner[k] == 2));
                check($sformatf("u%0d rdata", k), TW'({ic_rdata[k] ^ mem_rdata[k], dc_rdata[k] ^ mem_rdata[k]}), '0);
            end
        end
    end

    // Observed memory-side transactions {write, addr, wdata}, one per strobe rise.
    logic [TW-1:0] obs0_q[$], obs1_q[$];
    logic [TW-1:0] exp_q[$];
    bit            prev_strobe[2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit s;
            s = mem_read[k] | mem_write[k];
            if (s && !prev_strobe[k]) begin
                if (k == 0) obs0_q.push_back({mem_write[k], mem_addr[k], mem_wdata[k]});
                else        obs1_q.push_back({mem_write[k], mem_addr[k], mem_wdata[k]});
            end
            prev_strobe[k] = s;
        end
    end

    // Memory responder: pulses mem_ready after lat[k] cycles of a held strobe.
    bit            mem_auto[2] = '{1'b1, 1'b1};
    int            lat[2] = '{5, 5};
    int            cnt[2] = '{0, 0};
    logic [DW-1:0] fill[2];

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (mem_auto[k]) begin
                if (mem_ready[k]) begin
                    mem_ready[k] = 1'b0;
                    cnt[k] = 0;
                end else if (mem_read[k] | mem_write[k]) begin
                    cnt[k]++;
                    if (cnt[k] >= lat[k]) begin
                        mem_ready[k] = 1'b1;
                        mem_rdata[k] = fill[k];
                    end
                end else begin
                    cnt[k] = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cache driver: raise a strobe, hold it until ready, drop it at the next edge.
    task automatic do_req(input int k, input bit is_d, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd);
        int b;
        if (is_d) begin
            dc_read[k] = !wr; dc_write[k] = wr; dc_addr[k] = a; dc_wdata[k] = wd;
        end else begin
            ic_read[k] = !wr; ic_write[k] = wr; ic_addr[k] = a; ic_wdata[k] = wd;
        end
        b = 0;
        forever begin
            @(negedge clk);
            if (is_d ? dc_ready[k] : ic_ready[k]) break;
            if (++b > 200) begin
                total++; bad++;
                $display("FAIL u%0d ready timeout: addr %0h never completed", k, a);
                break;
            end
        end
        tick();
        if (is_d) begin dc_read[k] = 1'b0; dc_write[k] = 1'b0; end
        else      begin ic_read[k] = 1'b0; ic_write[k] = 1'b0; end
    endtask

    task automatic drain(input int k, input string name);
        logic [TW-1:0] got[$];
        got = (k == 0) ? obs0_q : obs1_q;
        check({name, " txn count"}, TW'(got.size()), TW'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s txn %0d", name, i), got[i], exp_q[i]);
        exp_q.delete();
        if (k == 0) obs0_q.delete(); else obs1_q.delete();
    endtask

    function automatic logic [TW-1:0] txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        return {wr, a, wd};
    endfunction

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        proc_reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ic_read[k] = 0; ic_write[k] = 0; dc_read[k] = 0; dc_write[k] = 0; mem_ready[k] = 0;
            ic_addr[k] = '0; dc_addr[k] = '0; ic_wdata[k] = '0; dc_wdata[k] = '0;
            mem_rdata[k] = '0; fill[k] = '0;
        end
        tick();
        model_on = 1'b1;
        tick();
        @(negedge clk);
        check("reset state", TW'(state_dbg[0]), TW'(0));
        check("reset strobes", TW'({mem_read[0], mem_write[0], mem_read[1], mem_write[1]}), TW'(0));
        check("reset addr", TW'(mem_addr[0]), TW'(0));
        check("reset ready", TW'({ic_ready[0], dc_ready[0]}), TW'(0));
        tick();
        proc_reset = 1'b0;
        tick();

        // Single I-cache read with a 5-cycle memory.
        fill[0] = {16{8'hA5}};
        fork
            do_req(0, 1'b0, 1'b0, 28'h0000010, '0);
            begin
                @(negedge clk);
                check("t1 strobe in request cycle", TW'(mem_read[0]), TW'(0));
                @(negedge clk);
                check("t1 strobe next cycle", TW'(mem_read[0]), TW'(1));
                check("t1 addr", TW'(mem_addr[0]), TW'(28'h0000010));
                n = 1;
                while (!ic_ready[0] && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("t1 latency", TW'(n), TW'(5));
                check("t1 ic_rdata", TW'(ic_rdata[0]), TW'({16{8'hA5}}));
                check("t1 dc_ready", TW'(dc_ready[0]), TW'(0));
            end
        join
        @(negedge clk);
        check("t1 idle after", TW'(state_dbg[0]), TW'(0));
        exp_q.push_back(txn(0, 28'h0000010, '0));
        drain(0, "t1");

        // Round-robin: last grant was I, so D wins the first tie.
        fill[0] = {4{32'h1234_5678}};
        lat[0] = 2;
        tick();
        fork
            do_req(0, 1'b0, 1'b0, 28'h0000020, '0);
            do_req(0, 1'b1, 1'b0, 28'h0000030, '0);
        join
        do_req(0, 1'b1, 1'b0, 28'h0000031, '0);
        fork
            do_req(0, 1'b0, 1'b0, 28'h0000021, '0);
            do_req(0, 1'b1, 1'b0, 28'h0000032, '0);
        join
        exp_q.push_back(txn(0, 28'h0000030, '0));
        exp_q.push_back(txn(0, 28'h0000020, '0));
        exp_q.push_back(txn(0, 28'h0000031, '0));
        exp_q.push_back(txn(0, 28'h0000021, '0));
        exp_q.push_back(txn(0, 28'h0000032, '0));
        drain(0, "t2 rr");

        // Fixed priority: back-to-back D requests starve the waiting I request.
        lat[1] = 3;
        tick();
        fork
            do_req(1, 1'b0, 1'b0, 28'h0000040, '0);
            for (int i = 0; i < 3; i++) do_req(1, 1'b1, 1'b0, 28'h0000050 + AW'(i), '0);
        join
        exp_q.push_back(txn(0, 28'h0000050, '0));
        exp_q.push_back(txn(0, 28'h0000051, '0));
        exp_q.push_back(txn(0, 28'h0000052, '0));
        exp_q.push_back(txn(0, 28'h0000040, '0));
        drain(1, "t3 fixed");

        // D-cache write-back then refill: two grants, exactly one write.
        tick();
        do_req(0, 1'b1, 1'b1, 28'h0000123, {4{32'hDEAD_BEEF}});
        do_req(0, 1'b1, 1'b0, 28'h0000456, '0);
        exp_q.push_back(txn(1, 28'h0000123, {4{32'hDEAD_BEEF}}));
        exp_q.push_back(txn(0, 28'h0000456, '0));
        drain(0, "t4 wb+refill");

        // Stray mem_ready while idle is ignored.
        mem_auto[0] = 1'b0;
        tick();
        mem_ready[0] = 1'b1;
        mem_rdata[0] = {4{32'hCAFE_F00D}};
        @(negedge clk);
        check("t5 ic_ready", TW'(ic_ready[0]), TW'(0));
        check("t5 dc_ready", TW'(dc_ready[0]), TW'(0));
        tick();
        mem_ready[0] = 1'b0;
        @(negedge clk);
        check("t5 state", TW'(state_dbg[0]), TW'(0));
        check("t5 strobes", TW'({mem_read[0], mem_write[0]}), TW'(0));
        mem_auto[0] = 1'b1;

        // Reset in the middle of an I-cache transaction.
        lat[0] = 20;
        tick();
        ic_read[0] = 1'b1;
        ic_addr[0] = 28'h0000077;
        tick();
        tick();
        @(negedge clk);
        check("t6 busy", TW'(state_dbg[0]), TW'(1));
        check("t6 strobe", TW'(mem_read[0]), TW'(1));
        tick();
        proc_reset = 1'b1;
        ic_read[0] = 1'b0;
        tick();
        proc_reset = 1'b0;
        @(negedge clk);
        check("t6 post-reset state", TW'(state_dbg[0]), TW'(0));
        check("t6 post-reset strobes", TW'({mem_read[0], mem_write[0]}), TW'(0));
        check("t6 post-reset addr", TW'(mem_addr[0]), TW'(0));
        check("t6 post-reset ready", TW'({ic_ready[0], dc_ready[0], mem_ready[0]}), TW'(0));
        lat[0] = 3;
        fill[0] = {4{32'h0BAD_CAFE}};
        tick();
        fork
            do_req(0, 1'b1, 1'b0, 28'h0000088, '0);
            begin
                n = 0;
                while (!dc_ready[0] && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("t6 dc_rdata", TW'(dc_rdata[0]), TW'({4{32'h0BAD_CAFE}}));
            end
        join
        exp_q.push_back(txn(0, 28'h0000077, '0));
        exp_q.push_back(txn(0, 28'h0000088, '0));
        drain(0, "t6 reset");

        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
